// File: rtl/minmax_acc.sv
// minmax_acc
// ----------
// Sequential min-reduction stage that sits directly behind the minMax
// semiring unit. It takes one minMax result per beat, folds BEATS of them
// into a running unsigned-min accumulator, feeds that accumulator back to
// the unit's e input, and hands out one reduced value per tile over a
// valid/ready handshake.
//
// Parameters
//   W       data width (unsigned), matches minMax W
//   BEATS   beats per tile (>= 1)
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   clear      synchronous abort of the partial tile
//   in_valid   in_data carries a valid beat
//   in_ready   stage can accept a beat this cycle
//   in_data    minMax.out for the current beat
//   e_out      registered running accumulator, wired to minMax.e
//   out_valid  a tile result is available
//   out_ready  consumer takes the result this cycle
//   out_data   reduced tile result
//   busy       a partial tile is in progress (beat count != 0)
//
// Configuration macro
//   MINMAX_ACC_SKID_EN  when defined, the HOLD state disappears: the result
//                       sits in an output register with its own valid flag
//                       and the next tile starts accumulating immediately.
//                       in_ready then depends combinationally on out_ready.
//                       When undefined, a two-state ACC/HOLD FSM stalls the
//                       input while a result is pending.

module minmax_acc #(
  parameter int W     = 16,
  parameter int BEATS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] e_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  localparam int              CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [W-1:0]     ACC_ONES  = '1;

  logic [W-1:0]     acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     out_data_q;

  logic [W-1:0]     fold;
  logic             accept;
  logic             last_beat;
  logic             final_beat;

  // Unsigned min of the incoming beat against the running accumulator.
  // All-ones is the identity, so an empty tile never biases the result.
  always_comb begin
    fold = (in_data <= acc_q) ? in_data : acc_q;
  end

  assign accept     = in_valid && in_ready;
  assign last_beat  = (cnt_q == LAST_BEAT);
  assign final_beat = accept && last_beat;

  // Accumulator, beat counter and result register. The final beat writes
  // the completed min straight into the output register and re-arms the
  // accumulator in the same cycle, so the next tile starts from identity.
  // A clear only touches the partial tile; the output register is left
  // alone so a pending result survives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= ACC_ONES;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else if (clear) begin
      acc_q <= ACC_ONES;
      cnt_q <= '0;
    end else if (final_beat) begin
      out_data_q <= fold;
      acc_q      <= ACC_ONES;
      cnt_q      <= '0;
    end else if (accept) begin
      acc_q <= fold;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign e_out    = acc_q;
  assign out_data = out_data_q;
  assign busy     = (cnt_q != '0);

`ifdef MINMAX_ACC_SKID_EN

  // Output register valid flag. Loading a new result wins over the
  // consumer taking the old one, which is what lets a freeing register and
  // an arriving final beat coexist in one cycle.
  logic out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
    end else if (final_beat) begin
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Only the beat that would complete a tile has to wait, and only while
  // the previous result is still sitting unclaimed in the output register.
  always_comb begin
    in_ready  = !rst && !clear && !(last_beat && out_valid_q && !out_ready);
    out_valid = out_valid_q;
  end

`else

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a completed tile parks in HOLD until the consumer takes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (final_beat) state_d = HOLD;
      HOLD:    if (out_ready)  state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // Outputs decoded from state only, so out_ready never reaches in_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACC:     in_ready  = !rst && !clear;
      HOLD:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

`endif

endmodule

// File: doc/minmax_acc.md
# minmax_acc

Sequential reduction stage directly downstream of the `minMax` semiring unit in the extended tensor core datapath. It consumes one `minMax` result per beat over a K-tile of `BEATS` beats and folds the results with unsigned min into a running accumulator. It drives that accumulator back to the unit's `e` input and emits one reduced result per tile over a valid/ready handshake.

## Interface
- `W`, 16: data width, unsigned; matches `minMax` `W`.
- `BEATS`, 8: beats per tile, ≥1; counter width `CNT_W = max(1,$clog2(BEATS))`.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clear` in 1: synchronous abort of the partial tile.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `in_data` in W: `minMax.out` for the current beat.
- `e_out` out W: running accumulator; wired to `minMax.e`.
- `out_valid` out 1: tile result available.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out W: reduced tile result.
- `busy` out 1: partial tile in progress (beat count ≠ 0).

## Operation
- Accumulator identity is all-ones ({W{1'b1}}). The fold is `acc_next = (in_data <= acc) ? in_data : acc`, unsigned. This is idempotent with `minMax`'s own `e` fold, so the result is correct whether `minMax.e` is driven by `e_out` or tied to all-ones.
- States: ACC (accepting beats) and HOLD (result pending, default build only).
- ACC: `in_ready=1` unless `clear` is high. Each accepted beat updates `acc` and increments `cnt`.
- Final beat (accepted with `cnt==BEATS-1`):
  - `out_data <= min(acc,in_data)` and `out_valid <= 1`.
  - `acc <=` all-ones and `cnt <= 0`.
  - Go to HOLD.
- HOLD: `in_ready=0`, `out_valid=1`, `out_data` stable. On `out_ready`: `out_valid <= 0`, go to ACC.
- `clear` in ACC: `acc <=` all-ones, `cnt <= 0`. `in_ready` is 0 in that cycle, so a concurrent beat is not accepted. `clear` does not affect a pending result in HOLD or the output register.
- `BEATS==1`: every accepted beat is a final beat.
- `e_out` is driven directly from `acc` (registered, no combinational path from `in_data`).
- `busy = (cnt != 0)`.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `e_out`=all-ones, `busy=0`, `in_ready=0` while `rst` is high. State=ACC, `cnt=0`.
- `rst` mid-tile discards the partial accumulation and any pending result. `in_ready=1` from the first cycle after `rst` deasserts.
- Latency: `out_valid` rises the cycle after the final beat is accepted.
- `e_out` reflects a beat's fold the cycle after acceptance. The upstream `minMax` sees the updated `e` on the next beat.
- Default throughput: one tile per `BEATS+1` cycles minimum; HOLD lasts ≥1 cycle.
- `out_valid` never drops without `out_ready`. `out_data` is stable while `out_valid && !out_ready`.

## Configuration
- `MINMAX_ACC_SKID_EN` defined:
  - The HOLD state is removed. The result lives in an output register with its own valid flag, and the next tile accumulates immediately.
  - `in_ready` drops only when `cnt==BEATS-1 && out_valid && !out_ready`. This is a combinational dependency on `out_ready`.
  - If the output register frees and a final beat arrives in the same cycle, both happen: the old result is taken and the new one is loaded.
  - Throughput: one tile per `BEATS` cycles with `out_ready=1`.
- Not defined: FSM behaviour as above, no combinational path from `out_ready` to `in_ready`.

## Test plan
- Reset check, `W=16`, `BEATS=4`: hold `rst` 3 cycles → `out_valid=0`, `out_data=0`, `e_out=16'hFFFF`, `busy=0`, `in_ready=0`; `in_ready=1` one cycle after release.
- Basic tile: beats 0x0050, 0x0030, 0x0070, 0x0040 back-to-back, `out_ready=1` → `e_out` sequence FFFF, 0050, 0030, 0030; `out_data=0x0030` one cycle after the 4th beat; then `e_out=FFFF`.
- Output stall: same tile with `out_ready=0` for 5 cycles → `out_valid` held, `out_data=0x0030` stable, `in_ready=0` (default build). With SKID_EN, the next 3 beats are accepted and the 4th is stalled until `out_ready=1`.
- Clear mid-tile: 2 beats (0x0010, 0x0020), then `clear` with `in_valid=1, in_data=0x0001` → beat not accepted, `busy=0`, `e_out=FFFF`. Next full tile 0x0100×4 → `out_data=0x0100`.
- Boundary values: tile 0xFFFF×4 → `out_data=0xFFFF`. Tile with 0x0000 in beat 3 → `out_data=0x0000`.
- `BEATS=1`: beats 0x0005, 0x0003 with `out_ready=1` → results 0x0005 then 0x0003 in order. Default build gives a bubble between results; with SKID_EN, one result per cycle.
